timeslice_arbiter: RTL

//  Shares one down-counting slice timer between NREQ requesters using round-robin arbitration.
//  The winner holds a one-hot grant for (dur+1) enabled cycles, or until it drops its request.

---
 rtl/timeslice_arbiter_pkg.sv | 24 ++
 rtl/timeslice_arbiter_rr_pick.sv | 37 +++
 rtl/timeslice_arbiter.sv | 118 +++++++++++
 3 files changed

// File: rtl/timeslice_arbiter_pkg.sv
//------------------------------------------------------------------------------
// timeslice_arbiter_pkg : shared state encoding and defaults for the arbiter
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package timeslice_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam int NREQ_DEFAULT = 4;
  localparam int CW_DEFAULT   = 4;

  // Rotation pointer width; at least one bit even for tiny NREQ.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/timeslice_arbiter_rr_pick.sv
//------------------------------------------------------------------------------
// timeslice_arbiter_rr_pick : combinational round-robin picker (doubled scan)
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module timeslice_arbiter_rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] onehot,
  output logic            any
);

  logic [2*NREQ-1:0] dbl;
  logic              hit;

  assign dbl = {req, req};
  assign any = |req;

  // The upper copy lets a scan starting at ptr wrap without modulo logic.
  always_comb begin
    onehot = '0;
    hit    = 1'b0;
    for (int i = 0; i < 2*NREQ; i++) begin
      if (!hit && (i >= int'(ptr)) && dbl[i]) begin
        onehot[i % NREQ] = 1'b1;
        hit              = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/timeslice_arbiter.sv
//------------------------------------------------------------------------------
// timeslice_arbiter : round-robin owner of a shared down-counting slice timer
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module timeslice_arbiter
  import timeslice_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEFAULT,
  parameter int CW   = CW_DEFAULT
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  input  logic [CW-1:0]   dur,
  output logic [NREQ-1:0] grant,
  output logic            busy,
  output logic [CW-1:0]   slice_cnt,
  output logic            done,
  output logic            early
);

  localparam int PW = ptr_width(NREQ);

  state_t          state, state_nxt;
  logic [PW-1:0]   ptr, ptr_nxt, ptr_after;
  logic [NREQ-1:0] grant_nxt;
  logic [CW-1:0]   cnt_nxt;
  logic            done_nxt, early_nxt;
  logic [NREQ-1:0] pick;
  logic            pick_any;

  timeslice_arbiter_rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr_pick (
    .req    (req),
    .ptr    (ptr),
    .onehot (pick),
    .any    (pick_any)
  );

  // Pointer moves one past the current owner so it is served last next round.
  always_comb begin
    ptr_after = ptr;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        ptr_after = (i == NREQ-1) ? '0 : PW'(i + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      grant     <= '0;
      slice_cnt <= '0;
      done      <= 1'b0;
      early     <= 1'b0;
      ptr       <= '0;
    end else begin
      state     <= state_nxt;
      grant     <= grant_nxt;
      slice_cnt <= cnt_nxt;
      done      <= done_nxt;
      early     <= early_nxt;
      ptr       <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    cnt_nxt   = slice_cnt;
    done_nxt  = 1'b0;
    early_nxt = 1'b0;
    ptr_nxt   = ptr;
    case (state)
      ST_IDLE: begin
        if (pick_any) begin
          state_nxt = ST_GRANT;
          grant_nxt = pick;
          cnt_nxt   = dur;
        end
      end
      ST_GRANT: begin
        // A dropped request ends the slice regardless of en or the count.
        if ((req & grant) == '0) begin
          state_nxt = ST_IDLE;
          grant_nxt = '0;
          done_nxt  = 1'b1;
          early_nxt = 1'b1;
          ptr_nxt   = ptr_after;
        end else if (en) begin
          if (slice_cnt != '0) begin
            cnt_nxt = slice_cnt - CW'(1);
          end else begin
            state_nxt = ST_IDLE;
            grant_nxt = '0;
            done_nxt  = 1'b1;
            ptr_nxt   = ptr_after;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  assign busy = (state == ST_GRANT);

endmodule

`default_nettype wire
